// File: rtl/stream_fifo_clearable_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_fifo_clearable_pkg
// Purpose  : Shared types and helpers for the clearable stream FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package stream_fifo_clearable_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISOLATE = 2'd1,
        DRAIN   = 2'd2,
        CLEAR   = 2'd3
    } clear_state_e;

    // A one-entry pointer still needs one bit to stay a legal vector.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ctrl_storage.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl_storage
// Purpose  : FIFO storage array with wrap-around pointers, count and flush.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl_storage
    import stream_fifo_clearable_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned USAGE_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [USAGE_WIDTH-1:0] count_o
);

    localparam int unsigned            c_ptr_width  = ptr_width(DEPTH);
    localparam logic [c_ptr_width-1:0] c_last_ptr   = c_ptr_width'(DEPTH - 1);
    localparam logic [USAGE_WIDTH-1:0] c_full_count = USAGE_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]  mem_d [DEPTH];
    logic [c_ptr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [USAGE_WIDTH-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
        // Flush discards bookkeeping only; stale array contents are unreachable.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == c_full_count);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

`ifndef COMMON_CELLS_ASSERTS_OFF
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= c_full_count)
        else $error("fifo count exceeds depth");
`endif

endmodule
`default_nettype wire

// File: rtl/stream_fifo_clearable_isolate.sv
`default_nettype none
// ============================================================================
// Module   : stream_fifo_clearable_isolate
// Purpose  : Stream FIFO with an isolate -> (drain) -> clear warm-reset FSM.
// Revision : 1.0 - initial release
// ============================================================================
module stream_fifo_clearable_isolate
    import stream_fifo_clearable_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned DEPTH          = 4,
    parameter bit          DRAIN_ON_CLEAR = 1'b0,
    parameter int unsigned USAGE_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    output logic                   clear_pending_o,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [USAGE_WIDTH-1:0] usage_o
);

    clear_state_e state_q, state_d;
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic         w_flush;

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = !w_full;
                valid_o = !w_empty;
                if (clear_i) begin
                    state_d = ISOLATE;
                end
            end
            ISOLATE: begin
                // Without drain the head beat is withdrawn here, unpopped.
                valid_o = DRAIN_ON_CLEAR ? !w_empty : 1'b0;
                state_d = (DRAIN_ON_CLEAR && !w_empty) ? DRAIN : CLEAR;
            end
            DRAIN: begin
                valid_o = !w_empty;
                if (w_empty) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign w_push          = valid_i & ready_o;
    assign w_pop           = valid_o & ready_i;
    assign w_flush         = (state_q == CLEAR);
    assign clear_pending_o = (state_q != IDLE);

    fifo_ctrl_storage #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .USAGE_WIDTH (USAGE_WIDTH)
    ) u_storage (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .data_i  (data_i),
        .data_o  (data_o),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (usage_o)
    );

`ifndef COMMON_CELLS_ASSERTS_OFF
    if (DEPTH < 2) begin : g_depth_check
        $error("DEPTH must be at least 2");
    end

    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> (!valid_i || $stable(data_i)))
        else $error("data_i changed while stalled");

    a_no_push_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != IDLE) |-> !w_push)
        else $error("push accepted during clear sequence");
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo_clearable_isolate.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_fifo_clearable_isolate
// Purpose  : Self-checking bench: flush-mode and drain-mode FIFOs side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_fifo_clearable_isolate;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b0;

    logic       f_pend, f_ready, f_valid;
    logic [7:0] f_data;
    logic [2:0] f_usage;
    logic       d_pend, d_ready, d_valid;
    logic [7:0] d_data;
    logic [2:0] d_usage;

    logic       sel = 1'b1;
    logic       m_pend, m_ready, m_valid;
    logic [7:0] m_data;
    logic [2:0] m_usage;

    int         checks = 0;
    int         errors = 0;
    int         pend_cnt;
    logic [7:0] exp_q [$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       c;
        logic       e_ready;
        logic       e_valid;
        logic [2:0] e_usage;
        logic       e_pend;
    } vec_t;

    localparam int c_nv = 16;
    vec_t vecs [c_nv];

    always #5 clk = ~clk;

    stream_fifo_clearable_isolate #(
        .DATA_WIDTH (8), .DEPTH (4), .DRAIN_ON_CLEAR (1'b0)
    ) u_dut_flush (
        .clk_i (clk), .rst_ni (rst_n), .clear_i (clear_i), .clear_pending_o (f_pend),
        .data_i (data_i), .valid_i (valid_i), .ready_o (f_ready),
        .data_o (f_data), .valid_o (f_valid), .ready_i (ready_i), .usage_o (f_usage)
    );

    stream_fifo_clearable_isolate #(
        .DATA_WIDTH (8), .DEPTH (4), .DRAIN_ON_CLEAR (1'b1)
    ) u_dut_drain (
        .clk_i (clk), .rst_ni (rst_n), .clear_i (clear_i), .clear_pending_o (d_pend),
        .data_i (data_i), .valid_i (valid_i), .ready_o (d_ready),
        .data_o (d_data), .valid_o (d_valid), .ready_i (ready_i), .usage_o (d_usage)
    );

    assign m_pend  = sel ? d_pend  : f_pend;
    assign m_ready = sel ? d_ready : f_ready;
    assign m_valid = sel ? d_valid : f_valid;
    assign m_data  = sel ? d_data  : f_data;
    assign m_usage = sel ? d_usage : f_usage;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r,
                                input logic er, input logic ev, input logic [2:0] eu);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.c = 1'b0;
        t.e_ready = er; t.e_valid = ev; t.e_usage = eu; t.e_pend = 1'b0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and update the scoreboard from the handshakes.
    task automatic tick(input logic v, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        valid_i = v; data_i = d; ready_i = r; clear_i = c;
        #1;
        if (v && m_ready) exp_q.push_back(d);
        if (m_valid && r) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected no beat", m_data);
            end else begin
                chk("beat_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; valid_i = 1'b0; clear_i = 1'b0; ready_i = 1'b0; data_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Tests 1 and 2: streaming and full-stall behaviour.
        vecs[0]  = mk(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 3'd0);
        vecs[1]  = mk(1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 3'd1);
        vecs[2]  = mk(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 3'd1);
        vecs[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1);
        vecs[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0);
        vecs[5]  = mk(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 3'd0);
        vecs[6]  = mk(1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 3'd1);
        vecs[7]  = mk(1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 3'd2);
        vecs[8]  = mk(1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 3'd3);
        vecs[9]  = mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 3'd4);
        vecs[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4);
        vecs[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3);
        vecs[12] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3);
        vecs[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2);
        vecs[14] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1);
        vecs[15] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0);

        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready_flush", f_ready, 1);
        chk("rst_valid_flush", f_valid, 0);
        chk("rst_pend_flush",  f_pend,  0);
        chk("rst_usage_flush", f_usage, 0);
        chk("rst_data_flush",  f_data,  0);
        chk("rst_ready_drain", d_ready, 1);
        chk("rst_valid_drain", d_valid, 0);
        chk("rst_pend_drain",  d_pend,  0);
        chk("rst_usage_drain", d_usage, 0);
        chk("rst_data_drain",  d_data,  0);
        rst_n = 1'b1;

        sel = 1'b1;
        for (int i = 0; i < c_nv; i++) begin
            tick(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
            chk($sformatf("vec%0d_ready", i), m_ready, vecs[i].e_ready);
            chk($sformatf("vec%0d_valid", i), m_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_usage", i), m_usage, vecs[i].e_usage);
            chk($sformatf("vec%0d_pend",  i), m_pend,  vecs[i].e_pend);
        end
        chk("t12_queue_empty", exp_q.size(), 0);

        // Test 3: flush mode discards three stored beats in a 2-cycle window.
        sel = 1'b0;
        do_reset();
        tick(1'b1, 8'hB1, 1'b0, 1'b0);
        tick(1'b1, 8'hB2, 1'b0, 1'b0);
        tick(1'b1, 8'hB3, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_usage_before", m_usage, 3);
        pend_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            if (m_pend) begin
                pend_cnt++;
                chk("t3_valid_in_clear", m_valid, 0);
                chk("t3_ready_in_clear", m_ready, 0);
            end
        end
        chk("t3_pend_cycles", pend_cnt, 2);
        chk("t3_usage_after", m_usage, 0);
        chk("t3_ready_after", m_ready, 1);
        chk("t3_flushed_entries", exp_q.size(), 3);
        exp_q.delete();

        // Test 4: drain mode delivers the stored beats before clearing.
        sel = 1'b1;
        do_reset();
        tick(1'b1, 8'hC1, 1'b0, 1'b0);
        tick(1'b1, 8'hC2, 1'b0, 1'b0);
        tick(1'b1, 8'hC3, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        pend_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            if (m_pend) begin
                pend_cnt++;
                chk("t4_ready_in_clear", m_ready, 0);
            end
        end
        chk("t4_pend_cycles", pend_cnt, 5);
        chk("t4_all_delivered", exp_q.size(), 0);
        chk("t4_usage_after", m_usage, 0);
        chk("t4_ready_after", m_ready, 1);

        // Test 5: push coincident with clear; clear re-asserted during drain.
        do_reset();
        tick(1'b1, 8'hD1, 1'b0, 1'b0);
        tick(1'b1, 8'hD2, 1'b0, 1'b0);
        tick(1'b1, 8'hD3, 1'b0, 1'b1);
        chk("t5_push_with_clear", exp_q.size(), 3);
        pend_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'h00, 1'b1, (i >= 1 && i <= 3));
            if (i == 0) chk("t5_usage_isolate", m_usage, 3);
            if (m_pend) pend_cnt++;
        end
        chk("t5_pend_cycles", pend_cnt, 5);
        chk("t5_all_delivered", exp_q.size(), 0);
        chk("t5_pend_after", m_pend, 0);

        // Test 6: asynchronous reset while draining.
        do_reset();
        tick(1'b1, 8'hE1, 1'b0, 1'b0);
        tick(1'b1, 8'hE2, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_pend_in_drain", m_pend, 1);
        chk("t6_valid_in_drain", m_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", m_ready, 1);
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_pend",  m_pend,  0);
        chk("t6_rst_usage", m_usage, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
